// File: rtl/comparator_bist_pkg.sv
// Shared types and defaults for the exhaustive comparator self-test block.
package comparator_bist_pkg;

   localparam int DEF_WIDTH         = 4;
   localparam int DEF_SETTLE_CYCLES = 1;
   localparam int SETTLE_CNT_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/comparator_bist.sv
// Exhaustive built-in self test for an external unsigned a > b comparator.
// Walks every (a, b) pair, counts mismatches and records the first failing pair.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | waiting for start, no results yet
//   ST_DRIVE  | vector on a/b, settle down-counter running
//   ST_SAMPLE | g compared against a > b, advance or finish
//   ST_DONE   | results held, start accepted as in ST_IDLE
module comparator_bist
   import comparator_bist_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   output logic [WIDTH-1:0]   a,
   output logic [WIDTH-1:0]   b,
   input  logic               g,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   err_count,
   output logic [WIDTH-1:0]   fail_a,
   output logic [WIDTH-1:0]   fail_b
);

   localparam int VEC_W = 2 * WIDTH;
   localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD =
      SETTLE_CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   // With no settle time each vector goes straight to the compare cycle.
   localparam state_t ST_VEC_FIRST = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_DRIVE;

   state_t                  state_q, state_d;
   logic [VEC_W-1:0]        vec_q;
   logic [SETTLE_CNT_W-1:0] settle_q;
   logic                    captured_q;
   logic                    start_run;
   logic                    sample_en;
   logic                    last_vec;
   logic                    mismatch;

   assign a        = vec_q[WIDTH-1:0];
   assign b        = vec_q[VEC_W-1:WIDTH];
   assign last_vec = &vec_q;
   assign mismatch = (g != (a > b));

   always_comb begin
      state_d   = state_q;
      start_run = 1'b0;
      sample_en = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_VEC_FIRST;
               start_run = 1'b1;
            end
         end
         ST_DRIVE: begin
            if (settle_q == '0) state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            sample_en = 1'b1;
            state_d   = last_vec ? ST_DONE : ST_VEC_FIRST;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         vec_q      <= '0;
         settle_q   <= '0;
         captured_q <= 1'b0;
         err_count  <= '0;
         fail_a     <= '0;
         fail_b     <= '0;
      end else begin
         state_q <= state_d;
         if (start_run) begin
            vec_q      <= '0;
            settle_q   <= SETTLE_LOAD;
            captured_q <= 1'b0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
         end
         if (state_q == ST_DRIVE && settle_q != '0) settle_q <= settle_q - 1'b1;
         if (sample_en) begin
            if (mismatch) begin
               err_count <= err_count + 1'b1;
               if (!captured_q) begin
                  captured_q <= 1'b1;
                  fail_a     <= a;
                  fail_b     <= b;
               end
            end
            // Final vector stays on a/b so the last pair is visible in DONE.
            if (!last_vec) begin
               vec_q    <= vec_q + 1'b1;
               settle_q <= SETTLE_LOAD;
            end
         end
      end
   end

   assign busy = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
   assign done = (state_q == ST_DONE);
   assign pass = done && (err_count == '0);

endmodule

// File: doc/comparator_bist.md
COMPARATOR_BIST -- requirements
Module: comparator_bist

Interface
REQ-001 Parameter: WIDTH, default 4, operand width of the comparator under test.
REQ-002 Parameter: SETTLE_CYCLES, default 1, clock cycles each vector is held before g is sampled; legal range 0..15.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset_n  input  1  synchronous reset, active-low.
REQ-005 Port: start  input  1  single-cycle request to run a full exhaustive test.
REQ-006 Port: a  output  WIDTH  operand A driven to the comparator under test.
REQ-007 Port: b  output  WIDTH  operand B driven to the comparator under test.
REQ-008 Port: g  input  1  comparator result read back; expected 1 iff a > b (unsigned).
REQ-009 Port: busy  output  1  high while a test run is in progress.
REQ-010 Port: done  output  1  high from run completion until the next accepted start or reset.
REQ-011 Port: pass  output  1  valid while done; 1 iff err_count == 0.
REQ-012 Port: err_count  output  2*WIDTH+1  number of mismatching vectors in the last run.
REQ-013 Port: fail_a, fail_b  output  WIDTH each  operands of the first mismatching vector; 0 if none.

Function
REQ-014 FSM states: IDLE, DRIVE, SAMPLE, DONE; DONE behaves as IDLE for start acceptance.
REQ-015 start is accepted only in IDLE or DONE; start while busy is ignored.
REQ-016 On accepted start: next cycle state=DRIVE, busy=1, done=0, vector counter=0, err_count=0, fail_a=fail_b=0, first-fail flag cleared.
REQ-017 Vector counter is 2*WIDTH bits; a = counter[WIDTH-1:0], b = counter[2*WIDTH-1:WIDTH]; a is the fastest-changing operand.
REQ-018 Each vector is held for SETTLE_CYCLES+1 cycles: SETTLE_CYCLES cycles in DRIVE, then one cycle in SAMPLE; SETTLE_CYCLES=0 goes directly to SAMPLE.
REQ-019 In SAMPLE, expected = (a > b) unsigned; if g != expected, err_count increments by 1 and, if first mismatch of the run, fail_a/fail_b capture a/b.
REQ-020 After SAMPLE of a non-final vector, counter increments and state returns to DRIVE (or SAMPLE if SETTLE_CYCLES=0).
REQ-021 After SAMPLE of the final vector (counter all ones), state=DONE, busy=0, done=1 next cycle; counter does not wrap into another run.
REQ-022 Cycles from accepted start to done=1: 1 + 2^(2*WIDTH)*(SETTLE_CYCLES+1); default = 513.
REQ-023 err_count width holds 2^(2*WIDTH) without overflow; no saturation logic.
REQ-024 a/b hold their last value (all ones) in DONE; err_count, fail_a, fail_b, pass stable until next accepted start.
REQ-025 Start accepted in the same cycle done is first asserted is impossible (done asserts after the cycle); start asserted coincident with done=1 is accepted.

Reset
REQ-026 reset_n=0 at a rising edge forces IDLE, a=b=0, busy=0, done=0, pass=0, err_count=0, fail_a=fail_b=0, counter=0, settle counter=0.
REQ-027 Reset overrides start and any in-progress run; the aborted run produces no done and no results.

Structure
REQ-028 Shared package holds the FSM state enum and default WIDTH/SETTLE_CYCLES constants.
REQ-029 Golden model (a > b) is inline; no sub-module needed except the comparator under test, instantiated only in the bench, not inside this block.

Verification
REQ-030 Correct comparator model, defaults: pulse start -> done=1 at cycle 513, pass=1, err_count=0, fail_a=fail_b=0.
REQ-031 g stuck at 0 -> err_count=120, pass=0, fail_a=1, fail_b=0.
REQ-032 g stuck at 1 -> err_count=136, pass=0, fail_a=0, fail_b=0.
REQ-033 Second start pulse at cycle 100 of a run -> ignored; done still at cycle 513; reset_n=0 at cycle 200 -> all outputs reset values, no done afterward.
REQ-034 SETTLE_CYCLES=0 with correct model -> done at cycle 257, pass=1; SETTLE_CYCLES=3 -> done at cycle 1025.
REQ-035 Back-to-back: start while done=1 after a failing run -> done drops next cycle, err_count and fail_a/fail_b cleared, new run completes with fresh results.
